// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART transmit definitions: line states, defaults and baud divisor helper.
package uart_tx_ctrl_pkg;

    localparam int unsigned DEF_CLK_FREQ = 50_000_000;
    localparam int unsigned DEF_BAUD     = 9600;
    localparam int unsigned DATA_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // Clocks per bit period.
    function automatic int unsigned calc_baud_div(input int unsigned clk_freq,
                                                  input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the UART transmitter; full/empty are registered.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            din,
    output logic [DW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DW-1:0]    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;
    logic [CNT_W-1:0] count_nxt_c;

    // Qualify requests against current occupancy and derive next count.
    always_comb begin
        do_push_c   = push && !full;
        do_pop_c    = pop && !empty;
        count_nxt_c = count;
        if (do_push_c && !do_pop_c) begin
            count_nxt_c = count + CNT_W'(1);
        end else if (!do_push_c && do_pop_c) begin
            count_nxt_c = count - CNT_W'(1);
        end
    end

    // Pointers, occupancy and registered status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt_c;
            full  <= (count_nxt_c == CNT_W'(DEPTH));
            empty <= (count_nxt_c == '0);
        end
    end

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= din;
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART 8N1 transmitter: buffers bytes in a FIFO and serialises them LSB first.
module uart_tx_ctrl
    import uart_tx_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned BAUD       = DEF_BAUD,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_req,
    input  logic [DATA_W-1:0] tx_data,
    output logic              fifo_full,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              overflow,
    output logic              tx
);

    localparam int unsigned BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
    localparam int unsigned BCNT_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BAUD_DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_DONE = BCNT_W'(BAUD_DIV - 2);

    tx_state_t         state;
    logic [BCNT_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shift;
    logic              push_c;
    logic              pop_c;
    logic              baud_last_c;
    logic [DATA_W-1:0] fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;

    // Push/pop qualification and end-of-bit-period detect.
    always_comb begin
        push_c      = tx_req && !fifo_full;
        pop_c       = (state == ST_IDLE) && (fifo_count != '0);
        baud_last_c = (baud_cnt == BCNT_LAST);
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (tx_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Frame sequencer: start bit, 8 data bits, stop bit; all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            tx_busy  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (fifo_count != '0) begin
                        shift   <= fifo_dout;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= ST_START;
                    end else begin
                        tx      <= 1'b1;
                        tx_busy <= push_c;
                    end
                end
                ST_START: begin
                    if (baud_last_c) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                        shift    <= {1'b0, shift[DATA_W-1:1]};
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BCNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (baud_last_c) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[0];
                            shift   <= {1'b0, shift[DATA_W-1:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BCNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (baud_last_c) begin
                        baud_cnt <= '0;
                        tx_busy  <= !fifo_empty || push_c;
                        state    <= ST_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + BCNT_W'(1);
                        tx_done  <= (baud_cnt == BCNT_DONE);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    // Sticky flag for writes attempted against a full buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (tx_req && fifo_full) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomised bench for uart_tx_ctrl against a queue-and-frame-timer reference model.
module tb_uart_tx_ctrl;

    localparam int unsigned BD    = 10;
    localparam int unsigned DEPTH = 4;
    localparam int          FRAME = 10 * BD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_req = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       fifo_full;
    logic       tx_busy;
    logic       tx_done;
    logic       overflow;
    logic       tx;

    uart_tx_ctrl #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .fifo_full (fifo_full),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .overflow  (overflow),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: byte queue plus position inside the current frame.
    logic [7:0] q[$];
    bit         m_act = 1'b0;
    int         m_t   = 0;
    logic [7:0] m_cur = 8'h00;
    bit         m_ovf = 1'b0;

    int cyc           = 0;
    int done_seen     = 0;
    int last_done_cyc = -1;
    int prev_done_cyc = -1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    function automatic logic exp_tx();
        int k;
        if (!m_act) return 1'b1;
        k = m_t / BD;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    task automatic model_reset();
        q.delete();
        m_act = 1'b0;
        m_t   = 0;
        m_ovf = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit push_ok;
        if (!rst) begin
            model_reset();
            return;
        end
        push_ok = tx_req && (q.size() < DEPTH);
        if (tx_req && q.size() == DEPTH) m_ovf = 1'b1;
        if (m_act) begin
            m_t++;
            if (m_t == FRAME) m_act = 1'b0;
        end else if (q.size() != 0) begin
            m_cur = q.pop_front();
            m_act = 1'b1;
            m_t   = 0;
        end
        if (push_ok) q.push_back(tx_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        check_eq("tx",        32'(tx),        32'(exp_tx()));
        check_eq("tx_done",   32'(tx_done),   32'(m_act && m_t == FRAME - 1));
        check_eq("tx_busy",   32'(tx_busy),   32'(m_act || q.size() != 0));
        check_eq("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
        check_eq("overflow",  32'(overflow),  32'(m_ovf));
        if (tx_done === 1'b1) begin
            done_seen++;
            prev_done_cyc = last_done_cyc;
            last_done_cyc = cyc;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_req  = 1'b1;
        tx_data = b;
        tick();
        tx_req  = 1'b0;
        tx_data = 8'($urandom);
    endtask

    task automatic drain(input string tag, input int bound);
        bit idle = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (!m_act && q.size() == 0) begin
                idle = 1'b1;
                break;
            end
            tick();
        end
        check_eq(tag, 32'(idle), 32'd1);
        repeat (3) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int push_cyc;
        int burst;

        // Reset held for five clocks.
        rst = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Single byte: latency and frame length.
        d0 = done_seen;
        push_byte(8'hA5);
        push_cyc = cyc;
        drain("s2_drain", 400);
        check_eq("s2_frames",  32'(done_seen - d0), 32'd1);
        check_eq("s2_latency", 32'(last_done_cyc - push_cyc), 32'd100);

        // Back-to-back pushes: one idle clock between frames.
        d0 = done_seen;
        push_byte(8'h01);
        push_byte(8'h80);
        drain("s3_drain", 600);
        check_eq("s3_frames",  32'(done_seen - d0), 32'd2);
        check_eq("s3_spacing", 32'(last_done_cyc - prev_done_cyc), 32'd101);

        // Six consecutive pushes: five frames, sixth dropped, overflow sticky.
        d0 = done_seen;
        for (int i = 0; i < 6; i++) push_byte(8'($urandom));
        drain("s4_drain", 1200);
        check_eq("s4_frames",   32'(done_seen - d0), 32'd5);
        check_eq("s4_overflow", 32'(overflow), 32'd1);

        // Reset during data bit 3 of 0xFF: line returns high at once, nothing follows.
        push_byte(8'hFF);
        repeat (46) tick();
        rst = 1'b0;
        #1;
        check_eq("s6_tx_async",   32'(tx), 32'd1);
        check_eq("s6_busy_async", 32'(tx_busy), 32'd0);
        check_eq("s6_ovf_async",  32'(overflow), 32'd0);
        model_reset();
        repeat (3) tick();
        rst = 1'b1;
        d0 = done_seen;
        repeat (200) tick();
        check_eq("s6_no_frame", 32'(done_seen - d0), 32'd0);

        // Random traffic with bursts that hit full, overflow and push-during-pop.
        burst = 0;
        for (int i = 0; i < 4000; i++) begin
            if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(1, 6);
            tx_req  = (burst > 0) || ($urandom_range(0, 99) == 0);
            tx_data = 8'($urandom);
            if (burst > 0) burst--;
            tick();
        end
        tx_req = 1'b0;
        drain("rand_drain", 1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
